raw_pattern_gen: RTL and testbench



---
 rtl/raw_pattern_gen.sv | 150 +++++++++++++++
 tb/tb_raw_pattern_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/raw_pattern_gen.sv
// Synthetic RGGB raw video source (vsync/hsync/den + 8-bit pixel) with frame-accurate start/stop.
// Latency: every output is registered and reflects the raster counter state one cycle earlier.
// Backpressure: none; free-running at pixel rate, enable is honoured only at frame boundaries.
module raw_pattern_gen #(
   parameter int SOURCE_H = 1024,
   parameter int SOURCE_V = 1024,
   parameter int H_BLANK  = 64,
   parameter int V_BLANK  = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic [1:0] pattern_sel,
   output logic       out_vsync,
   output logic       out_hsync,
   output logic       out_den,
   output logic [7:0] out_data,
   output logic       frame_done
);

   localparam logic [15:0] H_LAST   = 16'(SOURCE_H + H_BLANK - 1);
   localparam logic [15:0] V_LAST   = 16'(SOURCE_V + V_BLANK - 1);
   localparam logic [15:0] H_BL     = 16'(H_BLANK);
   localparam logic [15:0] H_BL_M1  = 16'(H_BLANK - 1);
   localparam logic [15:0] V_BL     = 16'(V_BLANK);
   localparam logic [15:0] BAR_LAST = 16'(SOURCE_H / 8 - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state_q;
   logic [15:0] h_cnt_q;
   logic [15:0] v_cnt_q;
   logic [7:0]  frame_cnt_q;
   logic [1:0]  pat_q;
   logic [15:0] bar_pix_q;
   logic [2:0]  bar_idx_q;

   logic        run;
   logic        wrap;
   logic [7:0]  x_lo;
   logic [4:0]  y_lo;
   logic        y_odd;
   logic        y_b4;
   logic        bar_ch;
   logic [7:0]  pix;
   logic        vsync_d;
   logic        hsync_d;
   logic        den_d;
   logic [7:0]  data_d;
   logic        frame_done_d;

   assign run  = (state_q == RUN);
   assign wrap = run && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

   // FSM and raster counters; the pattern is latched only at frame start so mid-frame changes are ignored
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         frame_cnt_q <= '0;
         pat_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               h_cnt_q <= '0;
               v_cnt_q <= '0;
               if (enable) begin
                  state_q <= RUN;
                  pat_q   <= pattern_sel;
               end
            end
            RUN: begin
               if (wrap) begin
                  h_cnt_q     <= '0;
                  v_cnt_q     <= '0;
                  frame_cnt_q <= frame_cnt_q + 8'd1;
                  if (enable) pat_q <= pattern_sel;
                  else        state_q <= IDLE;
               end else if (h_cnt_q == H_LAST) begin
                  h_cnt_q <= '0;
                  v_cnt_q <= v_cnt_q + 16'd1;
               end else begin
                  h_cnt_q <= h_cnt_q + 16'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Bar position tracks the current h_cnt; cleared on the cycle before x=0 so no divider is needed
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bar_pix_q <= '0;
         bar_idx_q <= '0;
      end else if (!run || h_cnt_q == H_BL_M1) begin
         bar_pix_q <= '0;
         bar_idx_q <= '0;
      end else if (h_cnt_q >= H_BL) begin
         if (bar_pix_q == BAR_LAST) begin
            bar_pix_q <= '0;
            bar_idx_q <= bar_idx_q + 3'd1;
         end else begin
            bar_pix_q <= bar_pix_q + 16'd1;
         end
      end
   end

   // Sync decode and pixel generation from the current counter state
   always_comb begin
      x_lo   = h_cnt_q[7:0] - H_BL[7:0];
      y_lo   = v_cnt_q[4:0] - V_BL[4:0];
      y_odd  = |(y_lo & 5'b00001);
      y_b4   = |(y_lo & 5'b10000);
      // Bar colours: R off for cyan/green/blue/black, G off for the last four, B off for odd bars
      if (!y_odd && !x_lo[0])     bar_ch = ~bar_idx_q[1];
      else if (y_odd && x_lo[0])  bar_ch = ~bar_idx_q[0];
      else                        bar_ch = ~bar_idx_q[2];
      case (pat_q)
         2'd0:    pix = 8'h80;
         2'd1:    pix = {8{bar_ch}};
         2'd2:    pix = x_lo + frame_cnt_q;
         default: pix = {8{x_lo[4] ^ y_b4}};
      endcase
      vsync_d      = run && (v_cnt_q < 16'd2);
      hsync_d      = run && (h_cnt_q < 16'd8);
      den_d        = run && (v_cnt_q >= V_BL) && (h_cnt_q >= H_BL);
      data_d       = den_d ? pix : 8'h00;
      frame_done_d = wrap;
   end

   // Output registers; async reset clears them immediately so an aborted frame leaves no trace
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_vsync  <= 1'b0;
         out_hsync  <= 1'b0;
         out_den    <= 1'b0;
         out_data   <= 8'h00;
         frame_done <= 1'b0;
      end else begin
         out_vsync  <= vsync_d;
         out_hsync  <= hsync_d;
         out_den    <= den_d;
         out_data   <= data_d;
         frame_done <= frame_done_d;
      end
   end

endmodule

// File: tb/tb_raw_pattern_gen.sv
// Directed bench for raw_pattern_gen with a 32x8 raster (16x4 active, 16/4 blanking).
// Latency: samples outputs 1 time unit after each rising edge, one frame = 256 cycles.
// Backpressure: not applicable; the DUT free-runs and the bench only observes.
module tb_raw_pattern_gen;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       enable;
   logic [1:0] pattern_sel;
   logic       out_vsync;
   logic       out_hsync;
   logic       out_den;
   logic [7:0] out_data;
   logic       frame_done;

   int n_assert = 0;
   int n_fail   = 0;

   logic       cap_vs   [256];
   logic       cap_hs   [256];
   logic       cap_den  [256];
   logic       cap_fd   [256];
   logic [7:0] cap_data [256];

   // Bar colour per active pixel, hand-derived for 2-pixel bars on RG and GB rows
   logic [7:0] bar_row0 [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF,
                                 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
   logic [7:0] bar_row1 [16] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00,
                                 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};

   always #5 clk = ~clk;

   raw_pattern_gen #(
      .SOURCE_H (16),
      .SOURCE_V (4),
      .H_BLANK  (16),
      .V_BLANK  (4)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable      (enable),
      .pattern_sel (pattern_sel),
      .out_vsync   (out_vsync),
      .out_hsync   (out_hsync),
      .out_den     (out_den),
      .out_data    (out_data),
      .frame_done  (frame_done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Record one full frame of outputs, starting at the output cycle of raster (0,0)
   task automatic capture(input bit drop_mid);
      for (int i = 0; i < 256; i++) begin
         cap_vs[i]   = out_vsync;
         cap_hs[i]   = out_hsync;
         cap_den[i]  = out_den;
         cap_fd[i]   = frame_done;
         cap_data[i] = out_data;
         if (drop_mid && i == 128) begin
            enable      = 1'b0;
            pattern_sel = 2'd0;
         end
         tick();
      end
   endtask

   function automatic logic [7:0] exp_data(input int pat, input int h, input int v, input logic [7:0] fc);
      int x;
      int y;
      x = h - 16;
      y = v - 4;
      if (v < 4 || h < 16) return 8'h00;
      case (pat)
         0:       return 8'h80;
         1:       return (y % 2 == 1) ? bar_row1[x] : bar_row0[x];
         2:       return 8'(x) + fc;
         default: return ((((x >> 4) ^ (y >> 4)) & 1) == 1) ? 8'hFF : 8'h00;
      endcase
   endfunction

   task automatic check_frame(input string tag, input int pat, input logic [7:0] fc);
      int vs_err = 0, hs_err = 0, den_err = 0, data_err = 0, fd_err = 0;
      int vs_cnt = 0, den_cnt = 0;
      for (int i = 0; i < 256; i++) begin
         int h = i % 32;
         int v = i / 32;
         if (cap_vs[i]  !== (v < 2))             vs_err++;
         if (cap_hs[i]  !== (h < 8))             hs_err++;
         if (cap_den[i] !== (v >= 4 && h >= 16)) den_err++;
         if (cap_fd[i]  !== (i == 255))          fd_err++;
         if (cap_data[i] !== exp_data(pat, h, v, fc)) data_err++;
         if (cap_vs[i] === 1'b1)  vs_cnt++;
         if (cap_den[i] === 1'b1) den_cnt++;
      end
      chk({tag, "_vsync_errs"}, vs_err, 0);
      chk({tag, "_vsync_cnt"}, vs_cnt, 64);
      chk({tag, "_hsync_errs"}, hs_err, 0);
      chk({tag, "_den_errs"}, den_err, 0);
      chk({tag, "_den_cnt"}, den_cnt, 64);
      chk({tag, "_data_errs"}, data_err, 0);
      chk({tag, "_fdone_errs"}, fd_err, 0);
   endtask

   // Request run from IDLE: sampled at the first edge, syncs visible after the second
   task automatic start_frames(input string tag);
      enable = 1'b1;
      tick();
      chk({tag, "_vsync_k"}, out_vsync, 0);
      tick();
      chk({tag, "_vsync_k1"}, out_vsync, 1);
      chk({tag, "_hsync_k1"}, out_hsync, 1);
      chk({tag, "_den_k1"}, out_den, 0);
   endtask

   initial begin
      logic fd_seen;
      reset_n     = 1'b0;
      enable      = 1'b1;
      pattern_sel = 2'd0;
      repeat (3) tick();
      chk("rst_vsync", out_vsync, 0);
      chk("rst_hsync", out_hsync, 0);
      chk("rst_den", out_den, 0);
      chk("rst_data", out_data, 0);
      chk("rst_fdone", frame_done, 0);

      #2 reset_n = 1'b1;
      start_frames("start");

      pattern_sel = 2'd1;
      capture(1'b0);
      check_frame("f0_grey", 0, 8'd0);

      pattern_sel = 2'd2;
      capture(1'b0);
      check_frame("f1_bars", 1, 8'd1);
      chk("bars_r0_x4", cap_data[148], 8'h00);
      chk("bars_r1_x9", cap_data[185], 8'hFF);

      capture(1'b0);
      check_frame("f2_ramp", 2, 8'd2);
      chk("ramp_f2_x5", cap_data[149], 8'h07);

      capture(1'b0);
      check_frame("f3_ramp", 2, 8'd3);
      chk("ramp_f3_x5", cap_data[149], 8'h08);

      repeat (251 * 256) tick();

      capture(1'b0);
      check_frame("f255_ramp", 2, 8'd255);
      chk("ramp_f255_x5", cap_data[149], 8'h04);

      pattern_sel = 2'd3;
      capture(1'b0);
      check_frame("f256_ramp", 2, 8'd0);
      chk("ramp_wrap_x5", cap_data[149], 8'h05);

      capture(1'b1);
      check_frame("stop_checker", 3, 8'd1);
      for (int i = 0; i < 4; i++) begin
         chk("stopped_outputs", {out_vsync, out_hsync, out_den, out_data, frame_done}, 0);
         tick();
      end

      start_frames("restart");
      capture(1'b0);
      check_frame("restart_grey", 0, 8'd2);

      repeat (148) tick();
      chk("midline_den", out_den, 1);
      chk("midline_data", out_data, 8'h80);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_outputs", {out_vsync, out_hsync, out_den, out_data, frame_done}, 0);
      fd_seen = 1'b0;
      for (int i = 0; i < 120; i++) begin
         tick();
         fd_seen = fd_seen | frame_done;
      end
      chk("no_partial_fdone", fd_seen, 0);

      pattern_sel = 2'd2;
      #2 reset_n = 1'b1;
      start_frames("post_rst");
      capture(1'b0);
      check_frame("post_rst_ramp", 2, 8'd0);
      chk("post_rst_x5", cap_data[149], 8'h05);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
